square_accumulator: RTL and testbench
=====================================

// Module: square_accumulator
// PURPOSE
//  Sequential squarer: the inverse of the team's iterative square-root unit.
//  - Method: on St, computes Sq = R*R by summing the first R odd numbers (1+3+5+...).
//  - Sits beside the square-root block: it regenerates N from a root and checks results.
//  - Uses the same St/Done start-complete handshake and exposes its state for debug.
// PARAMETERS
//  W  4  root width in bits; the square is 2W bits wide
// PORTS
//  clk     in   1     system clock; all logic on the rising edge
//  reset   in   1     synchronous, active-high reset
//  St      in   1     start request, level-sampled in IDLE
//  R       in   W     root operand, captured on the start edge
//  Done    out  1     high exactly while state==DONE
//  Busy    out  1     high in CHECK or ADD
//  Sq      out  2W    last result, held until the next DONE
//  state   out  3     current FSM state (debug)
//  NextSq  out  2W+1  (R+1)^2; present only with SQR_NEXT_EN
// BEHAVIOUR
//  Reset:
//   - Reset is synchronous and active-high; it overrides all else, including mid-operation.
//   - Outputs: state=IDLE, Done=0, Busy=0, Sq=0, NextSq=0.
//   - Internal: rootCopy=0, acc=0, odd=1, cnt=0.
//  State encodings: IDLE=0, CHECK=1, ADD=2, DONE=3, WAIT=4. Codes 5-7 go to IDLE.
//  IDLE:
//   - St=1: rootCopy<=R, acc<=0, odd<=1, cnt<=0, go to CHECK.
//   - St=0: stay in IDLE.
//  CHECK:
//   - cnt<rootCopy: go to ADD.
//   - otherwise: go to DONE, Sq<=acc, Done<=1.
//  ADD: acc<=acc+odd, odd<=odd+2, cnt<=cnt+1, go to CHECK.
//  DONE: Done<=0. If St=1 go to WAIT, else go to IDLE.
//  WAIT: stay while St=1; go to IDLE when St=0. St is never re-armed while held high.
//  Handshake:
//   - Done is a single-cycle pulse.
//   - St and R are ignored outside IDLE.
//   - R may change freely once captured.
//  Latency: DONE is entered 2R+2 rising edges after the edge that samples St, counting that edge.
//   - R=0: 2 edges.
//   - R=2^W-1: 2^(W+1) edges.
//  Widths:
//   - acc is 2W bits; its maximum (2^W-1)^2 never overflows.
//   - odd is W+1 bits; its maximum is 2^(W+1)-1.
//   - cnt is W bits.
//   - All arithmetic is unsigned with no saturation.
//  Sq changes only on entry to DONE; it is stable in every other cycle.
// CONFIGURATION
//  SQR_NEXT_EN defined:
//   - NextSq<=acc+odd on entry to DONE, giving (R+1)^2 with no extra cycles.
//   - Used by the verifier to bracket a root: Sq <= N < NextSq.
//  SQR_NEXT_EN undefined:
//   - The NextSq port and its 2W+1-bit register are removed.
//   - All other behaviour is identical.
// STRUCTURE
//  Shared package sqr_pkg:
//   - state encodings (IDLE..WAIT) and the state width constant (3);
//   - the default W.
//  Sub-module odd_accumulator:
//   - holds acc, odd and cnt;
//   - inputs: clear, step; outputs: acc, odd, cnt;
//   - the top level holds the FSM, rootCopy and the output registers.
// TESTING
//  - R=0, St pulse -> Done 2 edges after sampling; Sq=0; NextSq=1 with SQR_NEXT_EN.
//  - R=7 -> Done after 16 edges; Sq=49; Busy high for the 15 cycles between.
//  - R=15 -> Done after 32 edges; Sq=225; NextSq=256 (no truncation).
//  - St held high for 50 cycles with R=3 -> exactly one Done pulse, Sq=9, FSM parks in WAIT.
//  - R change during ADD -> result still uses the captured R.
//  - reset=1 while in ADD with R=12 -> next cycle state=0, Sq=0, Done=0; a new St with R=5 gives Sq=25.
//  - Round trip: for N=0..255, square-root unit result -> this block -> Sq<=N; with SQR_NEXT_EN also N<NextSq.

Source files
------------

// File: rtl/sqr_pkg.sv
// Shared definitions for the sequential squarer: FSM state encodings,
// the state width and the default root width.
package sqr_pkg;

   localparam int STATE_W       = 3;
   localparam int SQR_W_DEFAULT = 4;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      ADD   = 3'd2,
      DONE  = 3'd3,
      WAIT  = 3'd4
   } state_t;

endpackage

// File: rtl/odd_accumulator.sv
// Running sum of consecutive odd numbers 1+3+5+...
// acc holds the partial sum, odd the next odd number to add, cnt how many
// terms have been added so far (after k steps acc = k*k, odd = 2k+1).
module odd_accumulator
   import sqr_pkg::*;
#(
   parameter int W = SQR_W_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           clear,
   input  logic           step,
   output logic [2*W-1:0] acc,
   output logic [W:0]     odd,
   output logic [W-1:0]   cnt
);

   // Restart the series on reset/clear, otherwise add one odd term per step
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         acc <= '0;
         odd <= {{W{1'b0}}, 1'b1};
         cnt <= '0;
      end else if (step) begin
         acc <= acc + {{(W-1){1'b0}}, odd};
         odd <= odd + {{(W-1){1'b0}}, 2'b10};
         cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
      end else begin
         acc <= acc;
         odd <= odd;
         cnt <= cnt;
      end
   end

endmodule

// File: rtl/square_accumulator.sv
// Sequential squarer: Sq = R*R built by summing the first R odd numbers.
// St/Done start-complete handshake; FSM state exported for debug.
// Optional feature: define SQR_NEXT_EN to add the NextSq = (R+1)^2 output,
// captured alongside Sq at no extra latency.
module square_accumulator
   import sqr_pkg::*;
#(
   parameter int W = SQR_W_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               St,
   input  logic [W-1:0]       R,
   output logic               Done,
   output logic               Busy,
   output logic [2*W-1:0]     Sq,
   output logic [STATE_W-1:0] state
`ifdef SQR_NEXT_EN
   ,
   output logic [2*W:0]       NextSq
`endif
);

   state_t         cur_state;
   logic [W-1:0]   root_copy;
   logic           clear;
   logic           step;
   logic [2*W-1:0] acc;
   logic [W-1:0]   cnt;
`ifdef SQR_NEXT_EN
   logic [W:0]     odd;
   logic [2*W:0]   next_sum;
`else
   // odd only feeds NextSq, which this build does not have
   logic [W:0]     odd_unused;
`endif

   odd_accumulator #(.W(W)) u_odd_accumulator (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .step  (step),
      .acc   (acc),
`ifdef SQR_NEXT_EN
      .odd   (odd),
`else
      .odd   (odd_unused),
`endif
      .cnt   (cnt)
   );

`ifdef SQR_NEXT_EN
   // acc+odd is the square of the next root; one extra bit so (2^W)^2 fits
   assign next_sum = {1'b0, acc} + {{W{1'b0}}, odd};
`endif

   // Accumulator control: restart on an accepted start, step once per ADD
   always_comb begin
      clear = 1'b0;
      step  = 1'b0;
      clear = (cur_state == IDLE) && St;
      step  = (cur_state == ADD);
   end

   assign state = cur_state;

   // Control FSM with registered Done/Busy/Sq (and NextSq) outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state <= IDLE;
         root_copy <= '0;
         Done      <= 1'b0;
         Busy      <= 1'b0;
         Sq        <= '0;
`ifdef SQR_NEXT_EN
         NextSq    <= '0;
`endif
      end else begin
         case (cur_state)
            IDLE: begin
               Done <= 1'b0;
               if (St) begin
                  root_copy <= R;
                  cur_state <= CHECK;
                  Busy      <= 1'b1;
               end else begin
                  Busy      <= 1'b0;
               end
            end
            CHECK: begin
               if (cnt < root_copy) begin
                  cur_state <= ADD;
                  Busy      <= 1'b1;
               end else begin
                  cur_state <= DONE;
                  Busy      <= 1'b0;
                  Done      <= 1'b1;
                  Sq        <= acc;
`ifdef SQR_NEXT_EN
                  NextSq    <= next_sum;
`endif
               end
            end
            ADD: begin
               cur_state <= CHECK;
               Busy      <= 1'b1;
            end
            DONE: begin
               Done <= 1'b0;
               Busy <= 1'b0;
               // A start still held from the previous request must be released first
               if (St) begin
                  cur_state <= WAIT;
               end else begin
                  cur_state <= IDLE;
               end
            end
            WAIT: begin
               Done <= 1'b0;
               Busy <= 1'b0;
               if (St) begin
                  cur_state <= WAIT;
               end else begin
                  cur_state <= IDLE;
               end
            end
            default: begin
               cur_state <= IDLE;
               Done      <= 1'b0;
               Busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_square_accumulator.sv
// Directed self-checking bench for square_accumulator (W=4).
// NextSq checks are compiled in when SQR_NEXT_EN is defined.
module tb_square_accumulator;

   localparam int W = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           St;
   logic [W-1:0]   R;
   logic           Done;
   logic           Busy;
   logic [2*W-1:0] Sq;
   logic [2:0]     state;
`ifdef SQR_NEXT_EN
   logic [2*W:0]   NextSq;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   square_accumulator #(.W(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .St     (St),
      .R      (R),
      .Done   (Done),
      .Busy   (Busy),
      .Sq     (Sq),
      .state  (state)
`ifdef SQR_NEXT_EN
      ,
      .NextSq (NextSq)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Start one operation; returns with the DUT in DONE (or after a timeout).
   // edges counts rising edges from the one sampling St; busy_cnt counts
   // sampled cycles with Busy high. R switches to r_after once in ADD.
   task automatic do_op(input logic [W-1:0] r, input logic [W-1:0] r_after,
                        output int edges, output int busy_cnt);
      St = 1'b1;
      R  = r;
      tick();
      St       = 1'b0;
      edges    = 1;
      busy_cnt = (Busy === 1'b1) ? 1 : 0;
      while (Done !== 1'b1 && edges < 200) begin
         tick();
         edges++;
         if (edges == 2) R = r_after;
         if (Busy === 1'b1) busy_cnt++;
      end
   endtask

   initial begin
      int edges;
      int busy_cnt;
      int pulses;
      int root;
      logic [2*W-1:0] held_sq;

      reset = 1'b1;
      St    = 1'b0;
      R     = '0;
      tick();
      tick();
      check("rst_state", state, 0);
      check("rst_done",  Done,  0);
      check("rst_busy",  Busy,  0);
      check("rst_sq",    Sq,    0);
`ifdef SQR_NEXT_EN
      check("rst_nextsq", NextSq, 0);
`endif
      reset = 1'b0;
      tick();

      // R=0: two edges, Sq=0
      do_op(4'd0, 4'd0, edges, busy_cnt);
      check("r0_latency", edges, 2);
      check("r0_busy",    busy_cnt, 1);
      check("r0_done",    Done, 1);
      check("r0_state",   state, 3);
      check("r0_sq",      Sq, 0);
`ifdef SQR_NEXT_EN
      check("r0_nextsq",  NextSq, 1);
`endif
      tick();
      check("r0_pulse",   Done, 0);
      check("r0_idle",    state, 0);

      // R=7: 16 edges, Busy for the 15 cycles between
      do_op(4'd7, 4'd7, edges, busy_cnt);
      check("r7_latency", edges, 16);
      check("r7_busy",    busy_cnt, 15);
      check("r7_sq",      Sq, 49);
`ifdef SQR_NEXT_EN
      check("r7_nextsq",  NextSq, 64);
`endif
      tick();
      check("r7_pulse",   Done, 0);

      // Sq holds while idle even as R wanders
      held_sq = Sq;
      R = 4'd9;
      tick();
      R = 4'd2;
      tick();
      check("sq_hold", Sq, 49);
      check("sq_hold_idle", state, 0);

      // R=15: 32 edges, full-range result
      do_op(4'd15, 4'd15, edges, busy_cnt);
      check("r15_latency", edges, 32);
      check("r15_sq",      Sq, 225);
`ifdef SQR_NEXT_EN
      check("r15_nextsq",  NextSq, 256);
`endif
      tick();

      // St held 50 cycles with R=3: one pulse, park in WAIT
      St = 1'b1;
      R  = 4'd3;
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (Done === 1'b1) pulses++;
      end
      check("hold_pulses", pulses, 1);
      check("hold_state",  state, 4);
      check("hold_sq",     Sq, 9);
      check("hold_busy",   Busy, 0);
      St = 1'b0;
      tick();
      check("hold_release", state, 0);

      // R changed during ADD: captured R=6 still used
      do_op(4'd6, 4'd15, edges, busy_cnt);
      check("rchg_latency", edges, 14);
      check("rchg_sq",      Sq, 36);
      tick();

      // Reset in the middle of an R=12 operation
      St = 1'b1;
      R  = 4'd12;
      tick();
      St = 1'b0;
      tick();
      tick();
      tick();
      check("mid_in_add", state, 2);
      reset = 1'b1;
      tick();
      check("mid_rst_state", state, 0);
      check("mid_rst_sq",    Sq, 0);
      check("mid_rst_done",  Done, 0);
      check("mid_rst_busy",  Busy, 0);
      reset = 1'b0;
      tick();
      do_op(4'd5, 4'd5, edges, busy_cnt);
      check("after_rst_latency", edges, 12);
      check("after_rst_sq",      Sq, 25);
      tick();

      // Round trip: floor square root of N back through the squarer
      for (int n = 0; n < 256; n++) begin
         root = 0;
         while ((root + 1) * (root + 1) <= n) root++;
         do_op(root[W-1:0], root[W-1:0], edges, busy_cnt);
         check("rt_sq", Sq, root * root);
         check("rt_le", (32'(Sq) <= n) ? 1 : 0, 1);
`ifdef SQR_NEXT_EN
         check("rt_lt", (n < 32'(NextSq)) ? 1 : 0, 1);
`endif
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
